// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised register file with two write ports and a per-register busy scoreboard
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRP*AW-1:0]     rs,
  output logic [NRP*XLEN-1:0]   rdata,
  output logic [NRP-1:0]        rbusy,
  input  logic                  wa_en,
  input  logic [AW-1:0]         wa_rd,
  input  logic [XLEN-1:0]       wa_data,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  clr_en,
  input  logic [AW-1:0]         clr_rd,
  output logic                  busy_any,
  output logic [(1<<AW)-1:0]    busy_vec
);

  localparam int NREGS = 1 << AW;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wa_ok;
  logic             wb_ok;

  assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_rd == '0));
  assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_rd == '0));

  // Set wins over clear so a re-issued producer stays tracked
  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_nxt[i] = (busy[i] & ~(clr_en && (clr_rd == AW'(i))))
                  | (iss_en && (iss_rd == AW'(i)) && !((ZERO_REG != 0) && (i == 0)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wa_ok) regs[wa_rd] <= wa_data;
      if (wb_ok) regs[wb_rd] <= wb_data;
      busy <= busy_nxt;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] idx;
    logic          zero;
    logic          hit_a;
    logic          hit_b;
    logic          hit_c;

    assign idx   = rs[p*AW +: AW];
    assign zero  = (ZERO_REG != 0) && (idx == '0);
    assign hit_b = (BYPASS != 0) && wb_en && (wb_rd == idx);
    assign hit_a = (BYPASS != 0) && wa_en && (wa_rd == idx);
    assign hit_c = (BYPASS != 0) && clr_en && (clr_rd == idx);

    // Bypass is masked during reset so reads stay zero while it is held
    assign rdata[p*XLEN +: XLEN] = (reset || zero) ? '0
                                 : hit_b ? wb_data
                                 : hit_a ? wa_data
                                 : regs[idx];
    assign rbusy[p] = !zero && !hit_c && busy[idx];
  end

  assign busy_vec = busy;
  assign busy_any = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed and randomised checks of reg_file_sb in three builds
module tb_reg_file_sb;

  logic clk;
  logic reset;

  // Shared stimulus for the bypass and no-bypass 32-bit builds
  logic [9:0]  rs;
  logic        wa_en, wb_en, iss_en, clr_en;
  logic [4:0]  wa_rd, wb_rd, iss_rd, clr_rd;
  logic [31:0] wa_data, wb_data;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        busy_any_a, busy_any_b;
  logic [31:0] busy_vec_a, busy_vec_b;

  // 64-bit, 16-register, 3-port build
  logic [11:0]  x_rs;
  logic         x_wa_en, x_wb_en, x_iss_en, x_clr_en;
  logic [3:0]   x_wa_rd, x_wb_rd, x_iss_rd, x_clr_rd;
  logic [63:0]  x_wa_data, x_wb_data;
  logic [191:0] x_rdata;
  logic [2:0]   x_rbusy;
  logic         x_busy_any;
  logic [15:0]  x_busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_sb u_byp (
    .clk(clk), .reset(reset), .rs(rs), .rdata(rdata_a), .rbusy(rbusy_a),
    .wa_en(wa_en), .wa_rd(wa_rd), .wa_data(wa_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .clr_en(clr_en), .clr_rd(clr_rd),
    .busy_any(busy_any_a), .busy_vec(busy_vec_a)
  );

  reg_file_sb #(.BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .rs(rs), .rdata(rdata_b), .rbusy(rbusy_b),
    .wa_en(wa_en), .wa_rd(wa_rd), .wa_data(wa_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .clr_en(clr_en), .clr_rd(clr_rd),
    .busy_any(busy_any_b), .busy_vec(busy_vec_b)
  );

  reg_file_sb #(.XLEN(64), .AW(4), .NRP(3)) u_wide (
    .clk(clk), .reset(reset), .rs(x_rs), .rdata(x_rdata), .rbusy(x_rbusy),
    .wa_en(x_wa_en), .wa_rd(x_wa_rd), .wa_data(x_wa_data),
    .wb_en(x_wb_en), .wb_rd(x_wb_rd), .wb_data(x_wb_data),
    .iss_en(x_iss_en), .iss_rd(x_iss_rd), .clr_en(x_clr_en), .clr_rd(x_clr_rd),
    .busy_any(x_busy_any), .busy_vec(x_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; iss_en = 0; clr_en = 0;
  endtask

  logic [63:0] m [16];
  logic [15:0] mbusy;
  logic [15:0] nb;
  logic [3:0]  idx;
  logic [63:0] e;
  logic        eb;

  initial begin
    reset = 1; rs = '0; idle();
    wa_rd = '0; wb_rd = '0; iss_rd = '0; clr_rd = '0; wa_data = '0; wb_data = '0;
    x_rs = '0; x_wa_en = 0; x_wb_en = 0; x_iss_en = 0; x_clr_en = 0;
    x_wa_rd = '0; x_wb_rd = '0; x_iss_rd = '0; x_clr_rd = '0; x_wa_data = '0; x_wb_data = '0;
    for (int i = 0; i < 16; i++) m[i] = '0;
    mbusy = '0;

    @(negedge clk); @(negedge clk);
    check("reset_rdata", 64'(rdata_a), 64'h0);
    check("reset_busy_vec", 64'(busy_vec_a), 64'h0);
    check("reset_busy_any", 64'(busy_any_a), 64'h0);
    reset = 0;

    for (int i = 1; i < 32; i++) begin
      wa_en = 1; wa_rd = 5'(i); wa_data = 32'(i) * 32'h11111111;
      step();
    end
    idle();
    rs = {5'd31, 5'd5}; #1;
    check("preload_x5", 64'(rdata_a[31:0]), 64'h55555555);
    check("preload_x31", 64'(rdata_a[63:32]), 64'h1111110F);

    iss_en = 1; iss_rd = 5'd4; step(); idle(); #1;
    check("iss_x4_vec", 64'(busy_vec_a), 64'h10);

    // Asynchronous reset between edges, with a write pending in the same cycle
    @(negedge clk);
    wa_en = 1; wa_rd = 5'd2; wa_data = 32'hFFFF; rs = {5'd2, 5'd5};
    reset = 1; #1;
    check("async_rst_x5", 64'(rdata_a[31:0]), 64'h0);
    check("async_rst_bypass", 64'(rdata_a[63:32]), 64'h0);
    check("async_rst_busy_vec", 64'(busy_vec_a), 64'h0);
    check("async_rst_busy_any", 64'(busy_any_a), 64'h0);
    step(); reset = 0; idle(); #1;
    check("rst_write_ignored", 64'(rdata_a[63:32]), 64'h0);
    check("rst_x5_still_zero", 64'(rdata_a[31:0]), 64'h0);

    wa_en = 1; wa_rd = 5'd5; wa_data = 32'hDEADBEEF; step(); idle();
    rs = {5'd0, 5'd5}; #1;
    check("wr_x5_byp", 64'(rdata_a[31:0]), 64'hDEADBEEF);
    check("wr_x5_nobyp", 64'(rdata_b[31:0]), 64'hDEADBEEF);
    wa_en = 1; wa_rd = 5'd0; wa_data = 32'h1234; #1;
    check("x0_bypass_blocked", 64'(rdata_a[63:32]), 64'h0);
    step(); idle(); #1;
    check("x0_reads_zero", 64'(rdata_a[63:32]), 64'h0);
    check("x0_reads_zero_nobyp", 64'(rdata_b[63:32]), 64'h0);

    wa_en = 1; wa_rd = 5'd7; wa_data = 32'hAAAA0000;
    wb_en = 1; wb_rd = 5'd7; wb_data = 32'h0000BBBB;
    rs = {5'd7, 5'd5}; #1;
    check("conflict_byp_same", 64'(rdata_a[63:32]), 64'h0000BBBB);
    check("conflict_nobyp_same", 64'(rdata_b[63:32]), 64'h0);
    step(); idle(); #1;
    check("conflict_byp_after", 64'(rdata_a[63:32]), 64'h0000BBBB);
    check("conflict_nobyp_after", 64'(rdata_b[63:32]), 64'h0000BBBB);

    wb_en = 1; wb_rd = 5'd3; wb_data = 32'h55; rs = {5'd3, 5'd5}; #1;
    check("bypass_same", 64'(rdata_a[63:32]), 64'h55);
    check("nobyp_old", 64'(rdata_b[63:32]), 64'h0);
    step(); idle(); #1;
    check("nobyp_next", 64'(rdata_b[63:32]), 64'h55);

    rs = {5'd0, 5'd9};
    iss_en = 1; iss_rd = 5'd9; #1;
    check("iss_x9_before_edge", 64'(rbusy_a[0]), 64'h0);
    step(); idle(); #1;
    check("iss_x9_rbusy", 64'(rbusy_a[0]), 64'h1);
    check("iss_x9_busy_any", 64'(busy_any_a), 64'h1);
    check("iss_x9_vec", 64'(busy_vec_a), 64'h200);
    iss_en = 1; iss_rd = 5'd9; clr_en = 1; clr_rd = 5'd9; #1;
    check("clr_byp_rbusy", 64'(rbusy_a[0]), 64'h0);
    check("clr_nobyp_rbusy", 64'(rbusy_b[0]), 64'h1);
    step(); idle(); #1;
    check("iss_clr_same_vec", 64'(busy_vec_a), 64'h200);
    clr_en = 1; clr_rd = 5'd9; step(); idle(); #1;
    check("clr_x9_vec", 64'(busy_vec_a), 64'h0);
    check("clr_x9_busy_any", 64'(busy_any_a), 64'h0);
    iss_en = 1; iss_rd = 5'd0; step(); idle(); #1;
    check("iss_x0_vec", 64'(busy_vec_a), 64'h0);
    check("iss_x0_rbusy", 64'(rbusy_a[1]), 64'h0);
    clr_en = 1; clr_rd = 5'd12; step(); idle(); #1;
    check("clr_idle_vec", 64'(busy_vec_a), 64'h0);
    iss_en = 1; iss_rd = 5'd10; step(); idle();
    wa_en = 1; wa_rd = 5'd10; wa_data = 32'h1; step(); idle(); #1;
    check("write_keeps_busy", 64'(busy_vec_b), 64'h400);

    @(negedge clk);
    for (int c = 0; c < 1000; c++) begin
      x_wa_en = 1'($urandom); x_wa_rd = 4'($urandom); x_wa_data = {$urandom, $urandom};
      x_wb_en = 1'($urandom); x_wb_rd = 4'($urandom); x_wb_data = {$urandom, $urandom};
      x_iss_en = 1'($urandom); x_iss_rd = 4'($urandom);
      x_clr_en = 1'($urandom); x_clr_rd = 4'($urandom);
      x_rs = 12'($urandom);
      #1;
      for (int p = 0; p < 3; p++) begin
        idx = x_rs[p*4 +: 4];
        e = m[idx];
        eb = mbusy[idx];
        if (x_wb_en && x_wb_rd == idx) e = x_wb_data;
        else if (x_wa_en && x_wa_rd == idx) e = x_wa_data;
        if (x_clr_en && x_clr_rd == idx) eb = 1'b0;
        if (idx == 4'd0) begin e = '0; eb = 1'b0; end
        check("rnd_rdata", x_rdata[p*64 +: 64], e);
        check("rnd_rbusy", 64'(x_rbusy[p]), 64'(eb));
      end
      check("rnd_busy_vec", 64'(x_busy_vec), 64'(mbusy));
      check("rnd_busy_any", 64'(x_busy_any), 64'(|mbusy));
      step();
      if (x_wa_en && x_wa_rd != 4'd0) m[x_wa_rd] = x_wa_data;
      if (x_wb_en && x_wb_rd != 4'd0) m[x_wb_rd] = x_wb_data;
      nb = mbusy;
      if (x_clr_en) nb[x_clr_rd] = 1'b0;
      if (x_iss_en && x_iss_rd != 4'd0) nb[x_iss_rd] = 1'b1;
      mbusy = nb;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
